chardisp_vram_ctrl: RTL and testbench

Write-port controller in front of the chardisp character VRAM. It shares the single VRAM write port (WRADDR/BYTEEN/WREN/WRDATA) between two requesters:
- a host bus requester;
- an internal fill engine that clears or fills a word range with one 32-bit pattern (screen clear, line blank).

Arbitration is round-robin. All VRAM-side outputs are registered.

---
 rtl/chardisp_pkg.sv | 15 +
 rtl/chardisp_rr_arb2.sv | 28 ++
 rtl/chardisp_vram_ctrl.sv | 158 +++++++++++++++
 tb/tb_chardisp_vram_ctrl.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chardisp_pkg.sv
// Shared constants and fill-engine state encoding for the chardisp VRAM
// write-port controller.
package chardisp_pkg;

    localparam int VRAM_WORDS = 4000;
    localparam int WORD_SHIFT = 2;   // byte address = word index << WORD_SHIFT
    localparam int WIDX_W     = 12;  // width of a VRAM word index

    typedef enum logic [1:0] {
        F_IDLE = 2'd0,
        F_RUN  = 2'd1,
        F_DONE = 2'd2
    } fill_state_e;

endpackage

// File: rtl/chardisp_rr_arb2.sv
// Two-requester round-robin arbiter. Requester 0 is the host and has priority
// out of reset; the pointer only moves when both requesters compete.
module chardisp_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr_q, ptr_d;  // 1: requester 1 wins the next contested cycle

    // NOTE: every output gets a default before the branch, so no path infers a latch.
    always_comb begin
        gnt   = req;
        ptr_d = ptr_q;
        if (req == 2'b11) begin
            gnt   = ptr_q ? 2'b10 : 2'b01;
            ptr_d = ~ptr_q;
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= 1'b0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/chardisp_vram_ctrl.sv
// VRAM write-port controller: a host requester and a range-fill engine share
// one registered VRAM write port through a round-robin arbiter.
module chardisp_vram_ctrl #(
    parameter int ADDR_W     = 16,
    parameter int VRAM_WORDS = chardisp_pkg::VRAM_WORDS,
    parameter int CNT_W      = 13
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              H_REQ,
    input  logic [ADDR_W-1:0] H_ADDR,
    input  logic [3:0]        H_BYTEEN,
    input  logic [31:0]       H_DATA,
    output logic              H_ACK,
    output logic              H_ERR,
    input  logic              F_START,
    input  logic [11:0]       F_BASE,
    input  logic [CNT_W-1:0]  F_COUNT,
    input  logic [31:0]       F_DATA,
    output logic              F_BUSY,
    output logic              F_DONE,
    output logic [ADDR_W-1:0] WRADDR,
    output logic [3:0]        BYTEEN,
    output logic              WREN,
    output logic [31:0]       WRDATA
);

    import chardisp_pkg::fill_state_e;
    import chardisp_pkg::F_IDLE;
    import chardisp_pkg::F_RUN;
    import chardisp_pkg::WORD_SHIFT;
    import chardisp_pkg::WIDX_W;

    fill_state_e        state_q, state_d;
    logic [WIDX_W-1:0]  fidx_q, fidx_d;
    logic [CNT_W-1:0]   fcnt_q, fcnt_d;
    logic [31:0]        fdata_q, fdata_d;
    logic               f_busy, f_done;

    logic               wren_q, wren_d;
    logic               h_ack_q, h_ack_d;
    logic               h_err_q, h_err_d;
    logic [ADDR_W-1:0]  wraddr_q, wraddr_d;
    logic [3:0]         byteen_q, byteen_d;
    logic [31:0]        wrdata_q, wrdata_d;

    logic [ADDR_W-1:0]  h_word;
    logic               h_in_range, h_pend;
    logic [1:0]         req, gnt;

    // The host is not pending while its acknowledge is on the bus.
    assign h_word     = H_ADDR >> WORD_SHIFT;
    assign h_in_range = h_word < ADDR_W'(VRAM_WORDS);
    assign h_pend     = H_REQ && !h_ack_q;
    assign req        = {f_busy, h_pend};

    chardisp_rr_arb2 u_arb (
        .clk   (CLK),
        .rst_n (RST_N),
        .req   (req),
        .gnt   (gnt)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= F_IDLE;
            fidx_q  <= '0;
            fcnt_q  <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            fidx_q  <= fidx_d;
            fcnt_q  <= fcnt_d;
            fdata_q <= fdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        fidx_d  = fidx_q;
        fcnt_d  = fcnt_q;
        fdata_d = fdata_q;
        case (state_q)
            F_IDLE: begin
                if (F_START) begin
                    fidx_d  = F_BASE;
                    fcnt_d  = F_COUNT;
                    fdata_d = F_DATA;
                    state_d = (F_COUNT == '0) ? chardisp_pkg::F_DONE : F_RUN;
                end
            end
            F_RUN: begin
                if (gnt[1]) begin
                    // Word index wraps at the VRAM size, not at a power of two.
                    fidx_d = (fidx_q == WIDX_W'(VRAM_WORDS - 1)) ? '0 : fidx_q + WIDX_W'(1);
                    fcnt_d = fcnt_q - CNT_W'(1);
                    if (fcnt_q == CNT_W'(1)) state_d = chardisp_pkg::F_DONE;
                end
            end
            chardisp_pkg::F_DONE: state_d = F_IDLE;
            default:              state_d = F_IDLE;
        endcase
    end

    always_comb begin
        f_busy = (state_q == F_RUN);
        f_done = (state_q == chardisp_pkg::F_DONE);
    end

    always_comb begin
        wren_d   = 1'b0;
        h_ack_d  = gnt[0];
        h_err_d  = gnt[0] && !h_in_range;
        wraddr_d = wraddr_q;
        byteen_d = byteen_q;
        wrdata_d = wrdata_q;
        if (gnt[0] && h_in_range) begin
            wren_d   = 1'b1;
            wraddr_d = h_word << WORD_SHIFT;
            byteen_d = H_BYTEEN;
            wrdata_d = H_DATA;
        end else if (gnt[1]) begin
            wren_d   = 1'b1;
            wraddr_d = ADDR_W'(fidx_q) << WORD_SHIFT;
            byteen_d = 4'hf;
            wrdata_d = fdata_q;
        end
    end

    // NOTE: the write datapath registers are reset as well, so every output reads 0 in reset.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wren_q   <= 1'b0;
            h_ack_q  <= 1'b0;
            h_err_q  <= 1'b0;
            wraddr_q <= '0;
            byteen_q <= '0;
            wrdata_q <= '0;
        end else begin
            wren_q   <= wren_d;
            h_ack_q  <= h_ack_d;
            h_err_q  <= h_err_d;
            wraddr_q <= wraddr_d;
            byteen_q <= byteen_d;
            wrdata_q <= wrdata_d;
        end
    end

    assign H_ACK  = h_ack_q;
    assign H_ERR  = h_err_q;
    assign WREN   = wren_q;
    assign WRADDR = wraddr_q;
    assign BYTEEN = byteen_q;
    assign WRDATA = wrdata_q;
    assign F_BUSY = f_busy;
    assign F_DONE = f_done;

endmodule

// File: tb/tb_chardisp_vram_ctrl.sv
// Self-checking bench for chardisp_vram_ctrl: directed scenarios plus a
// randomized phase scored against a transaction queue and a VRAM image model.
module tb_chardisp_vram_ctrl;

    localparam int VW = 4000;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        H_REQ = 1'b0;
    logic [15:0] H_ADDR = '0;
    logic [3:0]  H_BYTEEN = '0;
    logic [31:0] H_DATA = '0;
    logic        H_ACK, H_ERR;
    logic        F_START = 1'b0;
    logic [11:0] F_BASE = '0;
    logic [12:0] F_COUNT = '0;
    logic [31:0] F_DATA = '0;
    logic        F_BUSY, F_DONE;
    logic [15:0] WRADDR;
    logic [3:0]  BYTEEN;
    logic        WREN;
    logic [31:0] WRDATA;

    chardisp_vram_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .H_REQ(H_REQ), .H_ADDR(H_ADDR), .H_BYTEEN(H_BYTEEN), .H_DATA(H_DATA),
        .H_ACK(H_ACK), .H_ERR(H_ERR),
        .F_START(F_START), .F_BASE(F_BASE), .F_COUNT(F_COUNT), .F_DATA(F_DATA),
        .F_BUSY(F_BUSY), .F_DONE(F_DONE),
        .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WRDATA(WRDATA)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [15:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } host_t;

    int          n_checks = 0;
    int          n_errors = 0;
    host_t       host_q[$];
    int          fill_q[$];
    logic [31:0] fill_pat = '0;
    bit          fill_active = 1'b0;
    bit          prev_ack = 1'b0;
    logic [31:0] exp_mem [VW];
    logic [31:0] dut_mem [VW];
    logic [15:0] obs_addr [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be,
                                          input logic [31:0] d);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    // Scoreboard: every acknowledged host request and every fill write is
    // matched against what the stimulus asked for.
    host_t mon_h;
    int    mon_idx;
    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_ack = 1'b0;
        end else begin
            if (H_ERR) check("err_with_ack", H_ACK, 1);
            if (H_ACK) begin
                check("ack_spacing", prev_ack, 0);
                check("ack_pending", host_q.size() > 0, 1);
                if (host_q.size() > 0) begin
                    mon_h = host_q.pop_front();
                    check("h_err", H_ERR, (mon_h.addr >> 2) >= VW);
                    check("h_wren", WREN, (mon_h.addr >> 2) < VW);
                    if ((mon_h.addr >> 2) < VW) begin
                        check("h_wraddr", WRADDR, mon_h.addr & 16'hfffc);
                        check("h_byteen", BYTEEN, mon_h.be);
                        check("h_wrdata", WRDATA, mon_h.data);
                    end
                end
            end else if (WREN) begin
                check("fill_expected", fill_q.size() > 0, 1);
                if (fill_q.size() > 0) begin
                    mon_idx = fill_q.pop_front();
                    check("f_wraddr", WRADDR, mon_idx * 4);
                    check("f_byteen", BYTEEN, 4'hf);
                    check("f_wrdata", WRDATA, fill_pat);
                end
            end
            if (WREN) begin
                check("wr_in_range", (WRADDR >> 2) < VW, 1);
                if ((WRADDR >> 2) < VW)
                    dut_mem[WRADDR >> 2] = merge(dut_mem[WRADDR >> 2], BYTEEN, WRDATA);
            end
            if (F_DONE) begin
                check("fdone_expected", fill_active && fill_q.size() == 0, 1);
                fill_active = 1'b0;
            end
            prev_ack = H_ACK;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the acknowledge cycle.
    task automatic host_write(input logic [15:0] a, input logic [3:0] be, input logic [31:0] d,
                              output int lat, output logic err, output logic wren,
                              output logic [15:0] wa, output logic [3:0] wbe,
                              output logic [31:0] wd);
        host_t t;
        bit    got = 1'b0;
        t.addr = a; t.be = be; t.data = d;
        host_q.push_back(t);
        if ((a >> 2) < VW) exp_mem[a >> 2] = merge(exp_mem[a >> 2], be, d);
        H_REQ = 1'b1; H_ADDR = a; H_BYTEEN = be; H_DATA = d;
        lat = 0;
        while (!got && lat < 50) begin
            @(negedge CLK);
            lat++;
            if (H_ACK) got = 1'b1;
        end
        check("h_ack_timeout", got, 1);
        err = H_ERR; wren = WREN; wa = WRADDR; wbe = BYTEEN; wd = WRDATA;
        @(posedge CLK); #1;
        H_REQ = 1'b0; H_ADDR = 16'($urandom); H_DATA = $urandom; H_BYTEEN = 4'($urandom);
    endtask

    task automatic fill_kick(input int base, input int count, input logic [31:0] pat);
        F_START = 1'b1; F_BASE = 12'(base); F_COUNT = 13'(count); F_DATA = pat;
        fill_pat = pat;
        fill_active = 1'b1;
        for (int i = 0; i < count; i++) begin
            fill_q.push_back((base + i) % VW);
            exp_mem[(base + i) % VW] = pat;
        end
    endtask

    task automatic fill_wait_idle();
        int w = 0;
        do begin
            @(negedge CLK);
            w++;
        end while ((F_BUSY || F_DONE) && w < 300);
        check("fill_idle_wait", w < 300, 1);
    endtask

    // Returns at posedge+1 of the cycle after F_START was sampled.
    task automatic fill_start(input int base, input int count, input logic [31:0] pat);
        fill_wait_idle();
        @(posedge CLK); #1;
        fill_kick(base, count, pat);
        @(posedge CLK); #1;
        F_START = 1'b0; F_DATA = $urandom; F_BASE = 12'($urandom); F_COUNT = 13'($urandom);
    endtask

    task automatic observe(input int n, output int wrens, output int dones,
                           output int first_w, output int last_w, output int first_d);
        wrens = 0; dones = 0; first_w = -1; last_w = -1; first_d = -1;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (WREN) begin
                if (wrens < 8) obs_addr[wrens] = WRADDR;
                if (first_w < 0) first_w = i;
                last_w = i;
                wrens++;
            end
            if (F_DONE) begin
                if (first_d < 0) first_d = i;
                dones++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat, wrens, dones, fw, lw, fd, gaps, cnt, bad;
        logic        err, wren, seen, done, first_is_host;
        logic [15:0] wa;
        logic [3:0]  wbe;
        logic [31:0] wd;
        host_t       t;

        for (int i = 0; i < VW; i++) begin exp_mem[i] = '0; dut_mem[i] = '0; end

        // Reset with a host request already pending.
        H_REQ = 1'b1; H_ADDR = 16'h0020; H_BYTEEN = 4'hf; H_DATA = 32'hcafef00d;
        repeat (3) @(negedge CLK);
        check("rst_ctrl", {WREN, H_ACK, H_ERR, F_BUSY, F_DONE, BYTEEN}, 0);
        check("rst_wraddr", WRADDR, 0);
        check("rst_wrdata", WRDATA, 0);
        t.addr = 16'h0020; t.be = 4'hf; t.data = 32'hcafef00d;
        host_q.push_back(t);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        @(negedge CLK);
        check("rel_first_edge", {H_ACK, WREN}, 2'b00);
        @(negedge CLK);
        check("rel_second_edge", {H_ACK, WREN}, 2'b11);
        @(posedge CLK); #1;
        H_REQ = 1'b0;
        repeat (2) @(posedge CLK); #1;

        // Single host write.
        host_write(16'h0010, 4'h3, 32'h12345678, lat, err, wren, wa, wbe, wd);
        check("host_latency", lat, 2);
        check("host_wren", wren, 1);
        check("host_wraddr", wa, 16'h0010);
        check("host_byteen", wbe, 4'h3);
        check("host_wrdata", wd, 32'h12345678);
        check("host_err", err, 0);

        // Out-of-range host word.
        host_write(16'(4000 << 2), 4'hf, 32'hdeadbeef, lat, err, wren, wa, wbe, wd);
        check("oor_err", err, 1);
        check("oor_wren", wren, 0);

        // Fill across the wrap point.
        fill_start(3998, 4, 32'h00000720);
        observe(20, wrens, dones, fw, lw, fd);
        check("wrap_wrens", wrens, 4);
        check("wrap_dones", dones, 1);
        check("wrap_consecutive", lw - fw, 3);
        check("wrap_a0", obs_addr[0], 16'(3998 * 4));
        check("wrap_a1", obs_addr[1], 16'(3999 * 4));
        check("wrap_a2", obs_addr[2], 16'h0000);
        check("wrap_a3", obs_addr[3], 16'h0004);

        // Zero-length fill.
        fill_start(100, 0, 32'h11111111);
        observe(6, wrens, dones, fw, lw, fd);
        check("zero_wrens", wrens, 0);
        check("zero_dones", dones, 1);
        check("zero_done_cycle", fd, 0);

        // Contention: fill start and host request in the same cycle, host held busy.
        fill_wait_idle();
        @(posedge CLK); #1;
        fill_kick(500, 6, 32'ha5a5a5a5);
        gaps = 0; seen = 1'b0; done = 1'b0; first_is_host = 1'b0;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    host_write(16'(16'h0100 + 4 * i), 4'($urandom), $urandom,
                               lat, err, wren, wa, wbe, wd);
            end
            begin
                @(posedge CLK); #1;
                F_START = 1'b0; F_DATA = $urandom;
            end
            begin
                for (int i = 0; i < 60 && !done; i++) begin
                    @(negedge CLK);
                    if (WREN && !seen) first_is_host = H_ACK;
                    if (WREN) seen = 1'b1;
                    else if (seen) gaps++;
                    if (F_DONE) done = 1'b1;
                end
            end
        join
        check("cont_first_host", first_is_host, 1);
        check("cont_gaps", gaps, 0);
        check("cont_done", done, 1);

        // Reset in the middle of a long fill.
        fill_start(0, 100, 32'h0f0f0f0f);
        cnt = 0;
        for (int i = 0; i < 60 && cnt < 10; i++) begin
            @(negedge CLK);
            if (WREN) cnt++;
        end
        check("mid_writes", cnt, 10);
        @(posedge CLK); #1;
        RST_N = 1'b0;
        host_q.delete(); fill_q.delete(); fill_active = 1'b0;
        @(negedge CLK);
        check("mid_rst_outs", {WREN, F_BUSY, F_DONE}, 3'b000);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        observe(10, wrens, dones, fw, lw, fd);
        check("mid_post_wrens", wrens, 0);
        check("mid_post_dones", dones, 0);
        fill_start(10, 3, 32'h5a5a0000);
        observe(10, wrens, dones, fw, lw, fd);
        check("mid_refill_wrens", wrens, 3);
        check("mid_refill_dones", dones, 1);

        // Randomized traffic scored against a VRAM image model.
        for (int i = 0; i < VW; i++) begin exp_mem[i] = '0; dut_mem[i] = '0; end
        @(posedge CLK); #1;
        fork
            begin
                for (int n = 0; n < 40; n++) begin
                    int          gap = $urandom_range(0, 3);
                    int          widx;
                    logic [15:0] a;
                    if (gap > 0) begin repeat (gap) @(posedge CLK); #1; end
                    widx = ($urandom_range(0, 99) < 85) ? $urandom_range(100, 1999)
                                                        : $urandom_range(4000, 16383);
                    a = {widx[13:0], 2'($urandom)};
                    host_write(a, 4'($urandom), $urandom, lat, err, wren, wa, wbe, wd);
                end
            end
            begin
                for (int n = 0; n < 6; n++)
                    fill_start($urandom_range(2000, 3999), $urandom_range(0, 100), $urandom);
            end
        join
        fill_wait_idle();
        repeat (4) @(negedge CLK);
        bad = 0;
        for (int i = 0; i < VW; i++) if (dut_mem[i] !== exp_mem[i]) bad++;
        check("mem_image", bad, 0);
        check("queues_drained", host_q.size() + fill_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
